// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//
// Serial pattern detector with programmable pattern, selectable overlapping
// or non-overlapping detection, and a saturating detection counter.
//
// Parameters
//   PAT_W     pattern length in bits (2..32)
//   CNT_W     detection counter width in bits (1..32)
//
// Ports
//   clk        in   1      clock, all state updates on rising edge
//   rst        in   1      synchronous reset, active low
//   in         in   1      serial data bit
//   in_valid   in   1      qualifies in; bit ignored when low
//   pattern    in   PAT_W  target sequence, pattern[PAT_W-1] received first
//   overlap    in   1      1 = overlapping detection, 0 = non-overlapping
//   clr_cnt    in   1      synchronous clear of det_count and cnt_sat
//   detected   out  1      registered one-cycle detection pulse
//   det_count  out  CNT_W  detections since reset or last clear (saturating)
//   cnt_sat    out  1      sticky: a detection arrived while det_count was full
// ---------------------------------------------------------------------------
module seq_detect_param #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             in_valid,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   input  logic             clr_cnt,
   output logic             detected,
   output logic [CNT_W-1:0] det_count,
   output logic             cnt_sat
);

   // Fill counter must represent 0..PAT_W inclusive.
   localparam int FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  history_reg, history_next;
   logic [FILL_W-1:0] fill_reg, fill_next;
   logic              detected_reg, detected_next;
   logic [CNT_W-1:0]  det_count_reg, det_count_next;
   logic              cnt_sat_reg, cnt_sat_next;

   logic [PAT_W-1:0]  hist_shift;
   logic [FILL_W-1:0] fill_inc;
   logic              match;

   // Post-shift view of the history and fill, used both for the match
   // decision and as the update value when the bit is valid.
   assign hist_shift = {history_reg[PAT_W-2:0], in};
   assign fill_inc   = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + FILL_W'(1);
   assign match      = in_valid && (fill_inc == FILL_FULL) && (hist_shift == pattern);

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      history_next   = history_reg;
      fill_next      = fill_reg;
      detected_next  = match;
      det_count_next = det_count_reg;
      cnt_sat_next   = cnt_sat_reg;

      if (in_valid) begin
         history_next = hist_shift;
         // Non-overlapping mode demands PAT_W fresh bits after a match, so
         // the fill restarts; the stale history is harmless because the
         // fill gate blocks any match until it is fully overwritten.
         fill_next    = (match && !overlap) ? '0 : fill_inc;
      end

      // A clear coinciding with a match keeps that match in the count.
      if (clr_cnt) begin
         det_count_next = match ? CNT_W'(1) : '0;
         cnt_sat_next   = 1'b0;
      end else if (match) begin
         if (&det_count_reg) begin
            cnt_sat_next = 1'b1;
         end else begin
            det_count_next = det_count_reg + CNT_W'(1);
         end
      end
   end

   // -----------------------------------------------------------------------
   // State registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         history_reg   <= '0;
         fill_reg      <= '0;
         detected_reg  <= 1'b0;
         det_count_reg <= '0;
         cnt_sat_reg   <= 1'b0;
      end else begin
         history_reg   <= history_next;
         fill_reg      <= fill_next;
         detected_reg  <= detected_next;
         det_count_reg <= det_count_next;
         cnt_sat_reg   <= cnt_sat_next;
      end
   end

   assign detected  = detected_reg;
   assign det_count = det_count_reg;
   assign cnt_sat   = cnt_sat_reg;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

   logic       clk;
   logic       rst;
   logic       in;
   logic       in_valid;
   logic [3:0] pattern;
   logic       overlap;
   logic       clr_cnt;

   logic       detected;
   logic [7:0] det_count;
   logic       cnt_sat;
   logic       detected2;
   logic [1:0] det_count2;
   logic       cnt_sat2;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: bits received since the last flush, plus counts.
   logic q[$];
   logic e_det;
   int   e_c8, e_c2;
   logic e_s8, e_s2;

   seq_detect_param #(.PAT_W(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pattern(pattern),
      .overlap(overlap), .clr_cnt(clr_cnt), .detected(detected),
      .det_count(det_count), .cnt_sat(cnt_sat)
   );

   seq_detect_param #(.PAT_W(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .pattern(pattern),
      .overlap(overlap), .clr_cnt(clr_cnt), .detected(detected2),
      .det_count(det_count2), .cnt_sat(cnt_sat2)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Drive one clock cycle, then advance the reference model.
   task automatic cycle(input logic r, input logic v, input logic b, input logic c);
      logic m;
      int   val;
      rst = r; in_valid = v; in = b; clr_cnt = c;
      @(posedge clk);
      #1;
      m = 1'b0;
      if (!r) begin
         q.delete();
         e_c8 = 0; e_c2 = 0; e_s8 = 0; e_s2 = 0;
      end else begin
         if (v) begin
            q.push_back(b);
            if (q.size() > 4) void'(q.pop_front());
            if (q.size() == 4) begin
               val = 0;
               foreach (q[i]) val = val * 2 + int'(q[i]);
               m = (val == int'(pattern));
            end
            if (m && !overlap) q.delete();
         end
         if (c) begin
            e_c8 = m ? 1 : 0; e_c2 = m ? 1 : 0; e_s8 = 0; e_s2 = 0;
         end else if (m) begin
            if (e_c8 == 255) e_s8 = 1; else e_c8++;
            if (e_c2 == 3)   e_s2 = 1; else e_c2++;
         end
      end
      e_det = m;
   endtask

   task automatic test_reset();
      pattern = 4'b1011; overlap = 1;
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (detected !== 1'b0 || detected2 !== 1'b0) begin
         n_fail++; $display("FAIL reset_detected got %b/%b want 0", detected, detected2);
      end
      n_checks++;
      if (det_count !== 8'd0 || det_count2 !== 2'd0) begin
         n_fail++; $display("FAIL reset_count got %0d/%0d want 0", det_count, det_count2);
      end
      n_checks++;
      if (cnt_sat !== 1'b0 || cnt_sat2 !== 1'b0) begin
         n_fail++; $display("FAIL reset_sat got %b/%b want 0", cnt_sat, cnt_sat2);
      end
      $display("test_reset done");
   endtask

   task automatic test_overlap(input logic ov);
      int bits[7] = '{1, 0, 1, 1, 0, 1, 1};
      int exp1[7] = '{0, 0, 0, 1, 0, 0, 1};
      int exp0[7] = '{0, 0, 0, 1, 0, 0, 0};
      logic want;
      pattern = 4'b1011; overlap = ov;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      foreach (bits[i]) begin
         cycle(1'b1, 1'b1, logic'(bits[i]), 1'b0);
         want = ov ? logic'(exp1[i]) : logic'(exp0[i]);
         n_checks++;
         if (detected !== want) begin
            n_fail++; $display("FAIL overlap%0d_bit%0d detected got %b want %b", ov, i + 1, detected, want);
         end
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (det_count !== (ov ? 8'd2 : 8'd1)) begin
         n_fail++; $display("FAIL overlap%0d_count got %0d want %0d", ov, det_count, ov ? 2 : 1);
      end
      $display("test_overlap ov=%0d count=%0d", ov, det_count);
   endtask

   task automatic test_ones(input logic ov);
      int exp1[6] = '{0, 0, 0, 1, 1, 1};
      int exp0[6] = '{0, 0, 0, 1, 0, 0};
      logic want;
      pattern = 4'b1111; overlap = ov;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 1'b0);
         want = ov ? logic'(exp1[i]) : logic'(exp0[i]);
         n_checks++;
         if (detected !== want) begin
            n_fail++; $display("FAIL ones%0d_bit%0d detected got %b want %b", ov, i + 1, detected, want);
         end
      end
      n_checks++;
      if (det_count !== (ov ? 8'd3 : 8'd1)) begin
         n_fail++; $display("FAIL ones%0d_count got %0d want %0d", ov, det_count, ov ? 3 : 1);
      end
      $display("test_ones ov=%0d count=%0d", ov, det_count);
   endtask

   task automatic test_gap();
      int vs[7]  = '{1, 1, 1, 0, 0, 0, 1};
      int bs[7]  = '{1, 0, 1, 0, 1, 0, 1};
      int ex[7]  = '{0, 0, 0, 0, 0, 0, 1};
      pattern = 4'b1011; overlap = 1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      foreach (vs[i]) begin
         cycle(1'b1, logic'(vs[i]), logic'(bs[i]), 1'b0);
         n_checks++;
         if (detected !== logic'(ex[i])) begin
            n_fail++; $display("FAIL gap_cyc%0d detected got %b want %0d", i, detected, ex[i]);
         end
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (detected !== 1'b0) begin
         n_fail++; $display("FAIL gap_after detected got %b want 0", detected);
      end
      $display("test_gap done");
   endtask

   task automatic test_saturate();
      int ec[8] = '{0, 0, 0, 1, 2, 3, 3, 3};
      int es[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
      pattern = 4'b1111; overlap = 1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 1'b0);
         n_checks++;
         if (det_count2 !== 2'(ec[i]) || cnt_sat2 !== logic'(es[i])) begin
            n_fail++; $display("FAIL sat_bit%0d count/sat got %0d/%b want %0d/%0d", i + 1, det_count2, cnt_sat2, ec[i], es[i]);
         end
      end
      n_checks++;
      if (det_count !== 8'd5 || cnt_sat !== 1'b0) begin
         n_fail++; $display("FAIL sat_wide got %0d/%b want 5/0", det_count, cnt_sat);
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (det_count2 !== 2'd0 || cnt_sat2 !== 1'b0 || det_count !== 8'd0) begin
         n_fail++; $display("FAIL sat_clear got %0d/%b/%0d want 0/0/0", det_count2, cnt_sat2, det_count);
      end
      // Clear must not disturb history/fill: one more 1 completes 1111 again.
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (detected2 !== 1'b1 || det_count2 !== 2'd1) begin
         n_fail++; $display("FAIL sat_post_clear got %b/%0d want 1/1", detected2, det_count2);
      end
      $display("test_saturate done");
   endtask

   task automatic test_reset_mid();
      int b1[3] = '{1, 0, 1};
      int b2[3] = '{0, 1, 1};
      int b3[4] = '{1, 0, 1, 1};
      int e3[4] = '{0, 0, 0, 1};
      pattern = 4'b1011; overlap = 1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      foreach (b1[i]) cycle(1'b1, 1'b1, logic'(b1[i]), 1'b0);
      // Reset cycle carries a valid 1 that must be discarded.
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      foreach (b2[i]) begin
         cycle(1'b1, 1'b1, logic'(b2[i]), 1'b0);
         n_checks++;
         if (detected !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_a%0d detected got %b want 0", i, detected);
         end
      end
      foreach (b3[i]) begin
         cycle(1'b1, 1'b1, logic'(b3[i]), 1'b0);
         n_checks++;
         if (detected !== logic'(e3[i])) begin
            n_fail++; $display("FAIL rstmid_b%0d detected got %b want %0d", i, detected, e3[i]);
         end
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_clr_match();
      int bs[7] = '{1, 0, 1, 1, 0, 1, 1};
      pattern = 4'b1011; overlap = 1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, logic'(bs[i]), 1'b0);
      cycle(1'b1, 1'b1, logic'(bs[6]), 1'b1);
      n_checks++;
      if (detected !== 1'b1 || det_count !== 8'd1 || cnt_sat !== 1'b0) begin
         n_fail++; $display("FAIL clr_match got %b/%0d/%b want 1/1/0", detected, det_count, cnt_sat);
      end
      $display("test_clr_match count=%0d", det_count);
   endtask

   task automatic test_random();
      logic r, v, b, c;
      pattern = 4'($urandom_range(0, 15)); overlap = 1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 600; i++) begin
         if (i % 60 == 0) pattern = 4'($urandom_range(0, 15));
         overlap = logic'($urandom_range(0, 1));
         r = ($urandom_range(0, 99) != 0);
         v = ($urandom_range(0, 3) != 0);
         b = logic'($urandom_range(0, 1));
         c = ($urandom_range(0, 39) == 0);
         cycle(r, v, b, c);
         n_checks++;
         if (detected !== e_det || detected2 !== e_det) begin
            n_fail++; $display("FAIL rand%0d detected got %b/%b want %b", i, detected, detected2, e_det);
         end
         n_checks++;
         if (det_count !== 8'(e_c8) || cnt_sat !== e_s8) begin
            n_fail++; $display("FAIL rand%0d count8 got %0d/%b want %0d/%b", i, det_count, cnt_sat, e_c8, e_s8);
         end
         n_checks++;
         if (det_count2 !== 2'(e_c2) || cnt_sat2 !== e_s2) begin
            n_fail++; $display("FAIL rand%0d count2 got %0d/%b want %0d/%b", i, det_count2, cnt_sat2, e_c2, e_s2);
         end
      end
      $display("test_random done count=%0d sat=%b", det_count, cnt_sat);
   endtask

   initial begin
      rst = 0; in = 0; in_valid = 0; pattern = 4'b1011; overlap = 1; clr_cnt = 0;
      e_det = 0; e_c8 = 0; e_c2 = 0; e_s8 = 0; e_s2 = 0;
      test_reset();
      test_overlap(1'b1);
      test_overlap(1'b0);
      test_ones(1'b1);
      test_ones(1'b0);
      test_gap();
      test_saturate();
      test_reset_mid();
      test_clr_match();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
